c432_key_loader: RTL and testbench
==================================

// Module: c432_key_loader
// PURPOSE
//  Serial key-programming controller for the locked c432 core. Receives the 23-bit key
//  (p1..p4 MUX key + X_1..X_19 XOR key) bit-serially, CRC-checks it, then swaps it
//  atomically into the active key register driving the core's key inputs.
//  Sits between the secure key store / test port and the combinational c432 instance.
// PARAMETERS
//  MUX_W     4   MUX key bits (p1..p4)
//  XOR_W     19  XOR key bits (X_1..X_19)
//  CRC_W     8   check bits trailing the key (CRC-8, poly 0x07, init 0x00, MSB first)
//  MAX_FAIL  3   failed loads before lockout (KEY_LOCKOUT_EN only)
// PORTS
//  clk        in   1      clock
//  rst        in   1      synchronous active-high reset
//  start      in   1      one-cycle pulse: begin a key load
//  s_valid    in   1      serial bit valid
//  s_data     in   1      serial bit
//  s_ready    out  1      controller accepts s_data this cycle
//  busy       out  1      load/check in progress
//  key_valid  out  1      active key loaded and CRC-clean
//  load_err   out  1      last load failed CRC (sticky until next start)
//  locked     out  1      lockout reached (0 when KEY_LOCKOUT_EN undefined)
//  mux_key    out  MUX_W  to p1..p4; bit0 = p1
//  xor_key    out  XOR_W  to X_1..X_19; bit0 = X_1
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; shadow, active key, CRC, counters cleared.
//  States: IDLE -> LOAD -> CHECK -> (ARMED | FAIL); ARMED/FAIL -> LOAD on start.
//  IDLE/ARMED/FAIL + start: bit counter=0, CRC=0, shadow=0, load_err=0 -> LOAD next cycle.
//  LOAD: s_ready=1, busy=1. Bit accepted iff s_valid&s_ready. Shadow shifts left; first
//   bit ends up in shadow[22] = mux_key[3] (p4); last key bit -> xor_key[0] (X_1).
//   CRC register updates with every accepted bit, key and check bits alike.
//   After 31st accepted bit (23 key + 8 CRC): LOAD -> CHECK; s_ready=0 from that next cycle.
//  CHECK (1 cycle, busy=1): CRC==0 -> ARMED: active<=shadow[22:0], key_valid=1 next cycle.
//   CRC!=0 -> FAIL: active<=0, key_valid=0, load_err=1, fail counter +1 (saturating).
//  Active key drives mux_key/xor_key; during a reload the previous active key and
//   key_valid remain unchanged until the CHECK result; never a partially shifted key.
//  start during LOAD/CHECK ignored. s_valid outside LOAD ignored (s_ready=0).
//  s_valid gaps in LOAD stall the counter; there is no timeout.
//  rst mid-load: immediate return to reset state; active key cleared.
// CONFIGURATION
//  C432_KEY_LOCKOUT_EN defined: fail counter reaching MAX_FAIL -> LOCKED state; locked=1,
//   key outputs 0, start ignored; exits only by rst. A successful load clears fail counter.
//  Undefined: no LOCKED state, locked tied 0, unlimited retries; fail counter unused.
// STRUCTURE
//  Package c432_key_pkg: state enum (IDLE,LOAD,CHECK,ARMED,FAIL,LOCKED), KEY_W=MUX_W+XOR_W,
//   CRC8_POLY=8'h07, FRAME_W=KEY_W+CRC_W.
//  Sub-module crc8_serial: 1-bit-per-cycle CRC-8 (clr, en, din, crc[7:0]).
// TESTING
//  1 Reset: all outputs 0, s_ready=0, state IDLE for 5 cycles with start=0.
//  2 start, 23 zero bits + CRC 8'h00 -> CHECK, then key_valid=1, mux/xor_key=0, load_err=0.
//  3 start, zero key + CRC 8'h01 -> key_valid=0, load_err=1, keys 0; next good load clears err.
//  4 Good load with non-zero key (bench-computed CRC), s_valid toggled every other cycle
//    -> same final key as back-to-back; first sent bit lands on mux_key[3].
//  5 ARMED with key K, reload with bad CRC -> K held during LOAD, cleared after CHECK;
//    start pulsed mid-LOAD ignored; rst at bit 10 -> full reset values next cycle.
//  6 With C432_KEY_LOCKOUT_EN: 3 bad loads -> locked=1, start ignored, rst clears lock.

Source files
------------

// File: rtl/c432_key_pkg.sv
// Shared types and constants for the c432 serial key loader: frame geometry,
// controller states and the single-bit CRC-8 step (poly 0x07, MSB first).
package c432_key_pkg;

  localparam int MUX_W    = 4;
  localparam int XOR_W    = 19;
  localparam int CRC_W    = 8;
  localparam int MAX_FAIL = 3;
  localparam int KEY_W    = MUX_W + XOR_W;
  localparam int FRAME_W  = KEY_W + CRC_W;
  localparam int CNT_W    = $clog2(FRAME_W);

  localparam logic [CRC_W-1:0] CRC8_POLY = 8'h07;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CHECK,
    ARMED,
    FAIL,
    LOCKED
  } state_e;

  // Feedback is the incoming bit XOR the register MSB; shift left, fold in the poly.
  function automatic logic [CRC_W-1:0] crc8_step(input logic [CRC_W-1:0] crc,
                                                 input logic             din);
    logic fb;
    fb = din ^ crc[CRC_W-1];
    return {crc[CRC_W-2:0], 1'b0} ^ (fb ? CRC8_POLY : '0);
  endfunction

endpackage

// File: rtl/crc8_serial.sv
// Bit-serial CRC-8 register: one bit per enabled cycle, synchronous clear.
// Feeding a frame followed by its own CRC leaves the register at zero.
module crc8_serial
  import c432_key_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             din,
  output logic [CRC_W-1:0] crc
);

  logic [CRC_W-1:0] crc_q;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      crc_q <= '0;
    end else if (en) begin
      crc_q <= crc8_step(crc_q, din);
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/c432_key_loader.sv
// Serial key loader for the locked c432 core: shifts in key + CRC-8, swaps the key
// into the active register only when clean. Optional lockout via C432_KEY_LOCKOUT_EN.
module c432_key_loader
  import c432_key_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             s_valid,
  input  logic             s_data,
  output logic             s_ready,
  output logic             busy,
  output logic             key_valid,
  output logic             load_err,
  output logic             locked,
  output logic [MUX_W-1:0] mux_key,
  output logic [XOR_W-1:0] xor_key
);

  localparam logic [CNT_W-1:0] KEY_CNT  = CNT_W'(KEY_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_W - 1);

  state_e             state_q;
  logic               s_ready_q, busy_q, key_valid_q, load_err_q;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [KEY_W-1:0]   shadow_q, shadow_d, active_q;
  logic [CRC_W-1:0]   crc;
  logic               accept, start_ok;

  assign accept    = s_valid && s_ready_q;
  assign start_ok  = start && (state_q inside {IDLE, ARMED, FAIL});
  assign bit_cnt_d = bit_cnt_q + CNT_W'(1);
  // Only key bits enter the shadow; trailing CRC bits must not push the key out.
  assign shadow_d  = (bit_cnt_q < KEY_CNT) ? {shadow_q[KEY_W-2:0], s_data} : shadow_q;

  crc8_serial u_crc (
    .clk (clk),
    .rst (rst),
    .clr (start_ok),
    .en  (accept),
    .din (s_data),
    .crc (crc)
  );

`ifdef C432_KEY_LOCKOUT_EN
  localparam logic [1:0] FAIL_LIMIT = 2'(MAX_FAIL);
  logic [1:0] fail_cnt_q, fail_cnt_d;
  logic       locked_q;

  assign fail_cnt_d = (fail_cnt_q == 2'b11) ? fail_cnt_q : fail_cnt_q + 2'd1;
  assign locked     = locked_q;
`else
  assign locked     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      s_ready_q   <= 1'b0;
      busy_q      <= 1'b0;
      key_valid_q <= 1'b0;
      load_err_q  <= 1'b0;
      bit_cnt_q   <= '0;
      shadow_q    <= '0;
      active_q    <= '0;
`ifdef C432_KEY_LOCKOUT_EN
      fail_cnt_q  <= '0;
      locked_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE, ARMED, FAIL: begin
          if (start_ok) begin
            state_q    <= LOAD;
            s_ready_q  <= 1'b1;
            busy_q     <= 1'b1;
            load_err_q <= 1'b0;
            bit_cnt_q  <= '0;
            shadow_q   <= '0;
          end
        end
        LOAD: begin
          if (accept) begin
            bit_cnt_q <= bit_cnt_d;
            shadow_q  <= shadow_d;
            if (bit_cnt_q == LAST_BIT) begin
              state_q   <= CHECK;
              s_ready_q <= 1'b0;
            end
          end
        end
        CHECK: begin
          busy_q <= 1'b0;
          if (crc == '0) begin
            state_q     <= ARMED;
            active_q    <= shadow_q;
            key_valid_q <= 1'b1;
`ifdef C432_KEY_LOCKOUT_EN
            fail_cnt_q  <= '0;
`endif
          end else begin
            active_q    <= '0;
            key_valid_q <= 1'b0;
            load_err_q  <= 1'b1;
`ifdef C432_KEY_LOCKOUT_EN
            fail_cnt_q  <= fail_cnt_d;
            if (fail_cnt_d >= FAIL_LIMIT) begin
              state_q  <= LOCKED;
              locked_q <= 1'b1;
            end else begin
              state_q  <= FAIL;
            end
`else
            state_q     <= FAIL;
`endif
          end
        end
        LOCKED: ;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign s_ready   = s_ready_q;
  assign busy      = busy_q;
  assign key_valid = key_valid_q;
  assign load_err  = load_err_q;
  assign mux_key   = active_q[KEY_W-1:XOR_W];
  assign xor_key   = active_q[XOR_W-1:0];

endmodule

// File: tb/tb_c432_key_loader.sv
// Self-checking bench for c432_key_loader: frame-level reference model with
// polynomial-division CRC, per-cycle output comparison, and directed scenarios.
module tb_c432_key_loader;

`ifdef C432_KEY_LOCKOUT_EN
  localparam bit LOCKOUT = 1'b1;
`else
  localparam bit LOCKOUT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_data = 1'b0;
  logic        s_ready, busy, key_valid, load_err, locked;
  logic [3:0]  mux_key;
  logic [18:0] xor_key;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  c432_key_loader dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .s_valid   (s_valid),
    .s_data    (s_data),
    .s_ready   (s_ready),
    .busy      (busy),
    .key_valid (key_valid),
    .load_err  (load_err),
    .locked    (locked),
    .mux_key   (mux_key),
    .xor_key   (xor_key)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Remainder of a 31-bit frame polynomial modulo x^8+x^2+x+1 by long division.
  function automatic logic [7:0] poly_rem(input logic [30:0] f);
    logic [30:0] r;
    r = f;
    for (int i = 30; i >= 8; i--)
      if (r[i]) r = r ^ (31'h107 << (i - 8));
    return r[7:0];
  endfunction

  function automatic logic [7:0] crc_of(input logic [22:0] key);
    return poly_rem({key, 8'h00});
  endfunction

  // Reference model: mode 0 = idle/armed/fail, 1 = loading, 2 = checking, 3 = locked.
  int          m_mode;
  int          m_fails;
  bit          m_q[$];
  logic        m_ready, m_busy, m_kv, m_err, m_lock;
  logic [22:0] m_key;

  always @(posedge clk) begin
    if (rst) begin
      m_mode = 0; m_fails = 0; m_q.delete();
      m_ready = 0; m_busy = 0; m_kv = 0; m_err = 0; m_lock = 0; m_key = '0;
    end else begin
      case (m_mode)
        0: if (start) begin
             m_mode = 1; m_q.delete(); m_err = 0; m_busy = 1; m_ready = 1;
           end
        1: if (s_valid) begin
             m_q.push_back(s_data);
             if (m_q.size() == 31) begin m_mode = 2; m_ready = 0; end
           end
        2: begin
             logic [30:0] f;
             f = '0;
             foreach (m_q[i]) f = {f[29:0], m_q[i]};
             m_busy = 0;
             if (poly_rem(f) == 8'h00) begin
               m_key = f[30:8]; m_kv = 1; m_fails = 0; m_mode = 0;
             end else begin
               m_key = '0; m_kv = 0; m_err = 1;
               if (m_fails < 3) m_fails++;
               if (LOCKOUT && m_fails >= 3) begin m_mode = 3; m_lock = 1; end
               else m_mode = 0;
             end
           end
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en)
      check("cycle", {4'h0, s_ready, busy, key_valid, load_err, locked, mux_key, xor_key},
                     {4'h0, m_ready, m_busy, m_kv, m_err, m_lock, m_key});
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Sends start then key+crc MSB first; gap idle cycles between bits, optional
  // start pulse at bit pulse_at, optional reset in place of bit abort_at.
  task automatic send_frame(input logic [22:0] key, input logic [7:0] crc,
                            input int gap, input int pulse_at, input int abort_at);
    logic [30:0] f;
    f = {key, crc};
    start = 1'b1;
    tick(1);
    start = 1'b0;
    for (int i = 30; i >= 0; i--) begin
      if (30 - i == abort_at) begin
        s_valid = 1'b0; rst = 1'b1;
        tick(1);
        rst = 1'b0;
        return;
      end
      s_valid = 1'b1;
      s_data  = f[i];
      start   = (30 - i == pulse_at);
      tick(1);
      start   = 1'b0;
      if (gap > 0) begin
        s_valid = 1'b0;
        tick(gap);
      end
    end
    s_valid = 1'b0;
  endtask

  localparam logic [22:0] K = 23'h5A5A5A;

  initial begin
    // Model pins: hand-divided remainders.
    check("pin_crc_1",  crc_of(23'h000001), 8'h07);
    check("pin_crc_2",  crc_of(23'h000002), 8'h0E);
    check("pin_crc_80", crc_of(23'h000080), 8'h89);

    // Reset and idle
    tick(3);
    chk_en = 1'b1;
    rst = 1'b0;
    tick(5);
    check("idle_ready", s_ready, 1'b0);
    check("idle_outs", {busy, key_valid, load_err, locked, mux_key, xor_key}, '0);

    // Zero key, clean CRC
    send_frame(23'h0, 8'h00, 0, -1, -1);
    check("zero_check_busy", busy, 1'b1);
    tick(2);
    check("zero_kv", key_valid, 1'b1);
    check("zero_err", load_err, 1'b0);

    // Zero key, bad CRC, then recovery
    send_frame(23'h0, 8'h01, 0, -1, -1);
    tick(2);
    check("bad_kv", key_valid, 1'b0);
    check("bad_err", load_err, 1'b1);
    send_frame(23'h0, 8'h00, 0, -1, -1);
    tick(2);
    check("recover_err", load_err, 1'b0);

    // Non-zero key with gapped valid, then back-to-back
    send_frame(K, crc_of(K), 1, -1, -1);
    tick(2);
    check("gap_mux", mux_key, 4'hB);
    check("gap_xor", xor_key, 19'h25A5A);
    check("gap_p4", mux_key[3], 1'b1);
    send_frame(K, crc_of(K), 0, -1, -1);
    tick(2);
    check("b2b_key", {mux_key, xor_key}, 23'h5A5A5A);

    // Bad reload with start pulsed mid-load: K held until CHECK completes
    send_frame(K, crc_of(K) ^ 8'hFF, 0, 5, -1);
    check("hold_mux", mux_key, 4'hB);
    check("hold_kv", key_valid, 1'b1);
    tick(1);
    check("cleared_key", {mux_key, xor_key}, 23'h0);
    check("cleared_err", load_err, 1'b1);

    // Reset in the middle of a load
    send_frame(K, crc_of(K), 0, -1, -1);
    tick(2);
    send_frame(K, crc_of(K), 0, -1, 10);
    check("rst_outs", {s_ready, busy, key_valid, load_err, locked, mux_key, xor_key}, '0);

    // Three bad loads: lockout when enabled, plain retry otherwise
    for (int n = 0; n < 3; n++) begin
      send_frame(K, 8'h00, 0, -1, -1);
      tick(2);
    end
    check("lock_flag", locked, LOCKOUT);
    send_frame(K, crc_of(K), 0, -1, -1);
    tick(2);
    check("after_lock_kv", key_valid, !LOCKOUT);
    check("after_lock_busy", busy, 1'b0);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(1);
    check("lock_cleared", locked, 1'b0);
    send_frame(K, crc_of(K), 0, -1, -1);
    tick(2);
    check("final_key", {key_valid, mux_key, xor_key}, {1'b1, K});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
